// File: rtl/scan_seq_pkg.sv
// Shared types and sizes for the address scan sequencer and its dwell timer.
package scan_seq_pkg;

   localparam int ADDR_W   = 3;
   localparam int NUM_ADDR = 8;
   localparam int DWELL_W  = 8;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t RUN  = 1'b1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Dwell counter: counts while enabled, pulses tc on the last cycle of each dwell period.
module dwell_timer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [DWELL_W-1:0] TC_VAL = DWELL_W'(DWELL_CYC - 1);

   logic [DWELL_W-1:0] count_reg;
   logic [DWELL_W-1:0] count_next;

   always_comb begin
      tc         = en && (count_reg == TC_VAL);
      count_next = count_reg;
      if (clr || tc) begin
         count_next = '0;
      end else if (en) begin
         count_next = count_reg + DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit decoder select through 0..7, holding each address DWELL_CYC cycles.
// Define SCAN_SEQ_CHECK_EN to add the decoder feedback port z and the sticky err flag.
module scan_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   input  logic continuous,
   output logic a2,
   output logic a1,
   output logic a0,
   output logic busy,
   output logic step,
   output logic done
`ifdef SCAN_SEQ_CHECK_EN
   ,
   input  logic [NUM_ADDR-1:0] z,
   output logic                err
`endif
);

   if (DWELL_CYC < 1 || DWELL_CYC > 255) begin : g_bad_dwell
      $error("scan_sequencer: DWELL_CYC must be in 1..255");
   end

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                cont_reg, cont_next;
   logic                step_reg, step_next;
   logic                done_reg, done_next;
   logic                dwell_tc;
   logic                timer_clr;
   logic                timer_en;

   // Counter is held at zero outside RUN and on abort, so every scan starts a fresh dwell.
   assign timer_en  = (state_reg == RUN);
   assign timer_clr = (state_reg != RUN) || stop;

   dwell_timer #(
      .DWELL_CYC (DWELL_CYC)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .en    (timer_en),
      .tc    (dwell_tc)
   );

`ifdef SCAN_SEQ_CHECK_EN
   logic                err_reg, err_next;
   logic [NUM_ADDR-1:0] z_mismatch;

   for (genvar gi = 0; gi < NUM_ADDR; gi++) begin : g_chk
      assign z_mismatch[gi] = z[gi] ^ (addr_reg == ADDR_W'(gi));
   end

   assign err = err_reg;
`endif

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      cont_next  = cont_reg;
      step_next  = 1'b0;
      done_next  = 1'b0;
`ifdef SCAN_SEQ_CHECK_EN
      err_next   = err_reg;
      if (state_reg == RUN && (|z_mismatch)) begin
         err_next = 1'b1;
      end
`endif
      if (state_reg == IDLE) begin
         if (start && !stop) begin
            state_next = RUN;
            addr_next  = '0;
            cont_next  = continuous;
`ifdef SCAN_SEQ_CHECK_EN
            err_next   = 1'b0;
`endif
         end
      end else begin
         // Abort takes priority over an advance landing in the same cycle.
         if (stop) begin
            state_next = IDLE;
            addr_next  = '0;
         end else if (dwell_tc) begin
            if (addr_reg != LAST_ADDR) begin
               addr_next = addr_reg + ADDR_W'(1);
               step_next = 1'b1;
            end else if (cont_reg) begin
               addr_next = '0;
               step_next = 1'b1;
            end else begin
               state_next = IDLE;
               addr_next  = '0;
               done_next  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         cont_reg  <= 1'b0;
         step_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifdef SCAN_SEQ_CHECK_EN
         err_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         cont_reg  <= cont_next;
         step_reg  <= step_next;
         done_reg  <= done_next;
`ifdef SCAN_SEQ_CHECK_EN
         err_reg   <= err_next;
`endif
      end
   end

   assign {a2, a1, a0} = addr_reg;
   assign busy         = (state_reg == RUN);
   assign step         = step_reg;
   assign done         = done_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: cycle table on a DWELL_CYC=2 instance plus hand sequences.
module tb_scan_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, stop, continuous;

   logic u10_a2, u10_a1, u10_a0, u10_busy, u10_step, u10_done;
   logic u2_a2,  u2_a1,  u2_a0,  u2_busy,  u2_step,  u2_done;
   logic u1_a2,  u1_a1,  u1_a0,  u1_busy,  u1_step,  u1_done;

`ifdef SCAN_SEQ_CHECK_EN
   logic [7:0] u10_z, u2_z, u1_z;
   logic       u10_err, u2_err, u1_err;
   logic       force_zero;
   assign u10_z = force_zero ? 8'h00 : (8'h01 << {u10_a2, u10_a1, u10_a0});
   assign u2_z  = 8'h01 << {u2_a2, u2_a1, u2_a0};
   assign u1_z  = 8'h01 << {u1_a2, u1_a1, u1_a0};
`endif

   scan_sequencer #(.DWELL_CYC(10)) u10 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .a2(u10_a2), .a1(u10_a1), .a0(u10_a0), .busy(u10_busy), .step(u10_step), .done(u10_done)
`ifdef SCAN_SEQ_CHECK_EN
      , .z(u10_z), .err(u10_err)
`endif
   );

   scan_sequencer #(.DWELL_CYC(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .a2(u2_a2), .a1(u2_a1), .a0(u2_a0), .busy(u2_busy), .step(u2_step), .done(u2_done)
`ifdef SCAN_SEQ_CHECK_EN
      , .z(u2_z), .err(u2_err)
`endif
   );

   scan_sequencer #(.DWELL_CYC(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .a2(u1_a2), .a1(u1_a1), .a0(u1_a0), .busy(u1_busy), .step(u1_step), .done(u1_done)
`ifdef SCAN_SEQ_CHECK_EN
      , .z(u1_z), .err(u1_err)
`endif
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic       cont;
      logic [2:0] addr;
      logic       busy;
      logic       step;
      logic       done;
   } vec_t;

   vec_t vecs[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic void add(input logic s, input logic p, input logic c,
                               input logic [2:0] a, input logic b, input logic st,
                               input logic d);
      vec_t v;
      v.start = s; v.stop = p; v.cont = c;
      v.addr = a; v.busy = b; v.step = st; v.done = d;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; continuous = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [15:0] pack10();
      return {10'd0, u10_a2, u10_a1, u10_a0, u10_busy, u10_step, u10_done};
   endfunction

   function automatic logic [15:0] pack2();
      return {10'd0, u2_a2, u2_a1, u2_a0, u2_busy, u2_step, u2_done};
   endfunction

   function automatic logic [15:0] pack1();
      return {10'd0, u1_a2, u1_a1, u1_a0, u1_busy, u1_step, u1_done};
   endfunction

   function automatic logic [15:0] expv(input int a, input logic b, input logic st, input logic d);
      logic [2:0] a3;
      a3 = 3'(a);
      return {10'd0, a3, b, st, d};
   endfunction

   initial begin
      int steps, dones, first_done;
`ifdef SCAN_SEQ_CHECK_EN
      force_zero = 1'b0;
`endif
      // Table for the DWELL_CYC=2 instance: one record per clock.
      add(0,0,0, 0,0,0,0);
      add(1,1,0, 0,0,0,0);
      add(1,0,0, 0,1,0,0);
      add(1,0,1, 0,1,0,0);
      for (int a = 1; a < 8; a++) begin
         add(0,0,1, 3'(a),1,1,0);
         add(0,0,1, 3'(a),1,0,0);
      end
      add(0,0,1, 0,0,0,1);
      add(0,0,0, 0,0,0,0);
      // stop coinciding with the 3->4 advance
      add(1,0,0, 0,1,0,0);
      add(0,0,0, 0,1,0,0);
      for (int a = 1; a < 4; a++) begin
         add(0,0,0, 3'(a),1,1,0);
         add(0,0,0, 3'(a),1,0,0);
      end
      add(0,1,0, 0,0,0,0);
      add(0,0,0, 0,0,0,0);
      // continuous wrap then stop
      add(1,0,1, 0,1,0,0);
      add(0,0,0, 0,1,0,0);
      for (int a = 1; a < 8; a++) begin
         add(0,0,0, 3'(a),1,1,0);
         add(0,0,0, 3'(a),1,0,0);
      end
      add(0,0,0, 0,1,1,0);
      add(0,0,0, 0,1,0,0);
      add(0,0,0, 1,1,1,0);
      add(0,1,0, 0,0,0,0);
      add(0,0,0, 0,0,0,0);

      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; continuous = 1'b0;
      tick();
      chk("reset_u10", pack10(), expv(0,0,0,0));
      chk("reset_u2",  pack2(),  expv(0,0,0,0));
      chk("reset_u1",  pack1(),  expv(0,0,0,0));
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         start = vecs[i].start; stop = vecs[i].stop; continuous = vecs[i].cont;
         tick();
         chk($sformatf("vec%0d", i), pack2(),
             {10'd0, vecs[i].addr, vecs[i].busy, vecs[i].step, vecs[i].done});
      end

      // Single pass at DWELL_CYC=10.
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      steps = 0; dones = 0;
      for (int k = 0; k < 85; k++) begin
         if (k < 80)
            chk($sformatf("p10_k%0d", k), pack10(),
                expv(k / 10, 1'b1, (k % 10 == 0) && (k > 0), 1'b0));
         else
            chk($sformatf("p10_k%0d", k), pack10(), expv(0, 1'b0, 1'b0, k == 80));
         steps += int'(u10_step);
         dones += int'(u10_done);
         tick();
      end
      chk("p10_step_count", 16'(steps), 16'd7);
      chk("p10_done_count", 16'(dones), 16'd1);

      // DWELL_CYC=1: address changes every cycle, done on the 8th advance.
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8)
            chk($sformatf("p1_k%0d", k), pack1(), expv(k, 1'b1, k > 0, 1'b0));
         else
            chk($sformatf("p1_k%0d", k), pack1(), expv(0, 1'b0, 1'b0, k == 8));
         tick();
      end

      // Asynchronous reset mid-dwell at address 5, then full rescan.
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (55) tick();
      chk("pre_rst_addr5", pack10(), expv(5, 1'b1, 1'b0, 1'b0));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", pack10(), expv(0, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      chk("rst_held_no_done", pack10(), expv(0, 1'b0, 1'b0, 1'b0));
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rescan_entry", pack10(), expv(0, 1'b1, 1'b0, 1'b0));
      first_done = -1;
      for (int k = 0; k < 85; k++) begin
         if (u10_done && first_done < 0) first_done = k;
         tick();
      end
      chk("rescan_done_latency", 16'(first_done), 16'd80);

`ifdef SCAN_SEQ_CHECK_EN
      // Decoder feedback checking.
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (81) tick();
      chk("err_clean_pass", {15'd0, u10_err}, 16'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      chk("err_pre_force", {12'd0, u10_a2, u10_a1, u10_a0, u10_err}, {12'd0, 3'd3, 1'b0});
      force_zero = 1'b1;
      tick();
      force_zero = 1'b0;
      chk("err_set", {15'd0, u10_err}, 16'd1);
      repeat (60) tick();
      chk("err_hold_idle", {14'd0, u10_busy, u10_err}, 16'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_clear_on_start", {14'd0, u10_busy, u10_err}, 16'd2);
      chk("err_u2_u1_clean", {14'd0, u2_err, u1_err}, 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 10, clock cycles each select address is held (legal 1..255; 0 is an elaboration error).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  begin a scan (level sampled each cycle).
REQ-005 SHALL have port stop  input  1  abort the current scan.
REQ-006 SHALL have port continuous  input  1  1 = wrap 7->0 indefinitely, 0 = single pass.
REQ-007 SHALL have port a2, a1, a0  output  1 each  registered 3-bit select driven straight into the 3-to-8 decoder (a2 = MSB).
REQ-008 SHALL have port busy  output  1  high in RUN.
REQ-009 SHALL have port step  output  1  one-cycle pulse on each address change within a scan.
REQ-010 SHALL have port done  output  1  one-cycle pulse at single-pass completion.

Function
REQ-011 SHALL implement FSM states IDLE and RUN, plus an internal dwell counter of 8 bits.
REQ-012 IDLE: start=1 and stop=0 -> next cycle RUN, address 0, counter 0, busy 1; step not pulsed on entry.
REQ-013 continuous SHALL be captured at the start cycle; later changes ignored until next start.
REQ-014 RUN: counter increments each cycle; at counter == DWELL_CYC-1 counter clears and address advances.
REQ-015 Advance with address < 7: address+1, step=1 for one cycle.
REQ-016 Advance at address 7, continuous captured 1: address 0, step=1, remain RUN.
REQ-017 Advance at address 7, continuous captured 0: done=1 for one cycle, state IDLE, address 0, busy 0, step 0.
REQ-018 stop=1 in RUN SHALL win over any advance in that cycle: next cycle IDLE, address 0, no done, no step.
REQ-019 start in RUN SHALL be ignored; start and stop both high in IDLE SHALL leave the block in IDLE.
REQ-020 DWELL_CYC=1: address SHALL change every cycle; single pass = 8 RUN cycles, done on the 8th advance.
REQ-021 Single pass latency: done SHALL assert exactly 8*DWELL_CYC cycles after the cycle following start.
REQ-022 a2..a0, busy, step, done SHALL all be registered outputs (no combinational path from inputs).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, address 0, counter 0, busy/step/done 0, captured continuous 0, err 0 (if present).
REQ-024 Reset mid-scan SHALL abandon the scan without a done pulse; first start after release behaves per REQ-012.

Configuration
REQ-025 Macro SCAN_SEQ_CHECK_EN defined: add port z  input  8  decoder outputs z7..z0 (fed back), and port err  output  1  sticky mismatch flag.
REQ-026 With SCAN_SEQ_CHECK_EN: each RUN cycle, z != one-hot of current address SHALL set err the next cycle; err cleared only by reset or an accepted start.
REQ-027 Without SCAN_SEQ_CHECK_EN: ports z and err SHALL not exist and no checking logic SHALL be built.

Structure
REQ-028 Package scan_seq_pkg SHALL hold the state typedef (IDLE, RUN), ADDR_W = 3, NUM_ADDR = 8, DWELL_W = 8.
REQ-029 Sub-module dwell_timer (count, terminal-count pulse, sync clear) SHALL be instantiated once; the FSM and checker stay in scan_sequencer.

Verification
REQ-030 DWELL_CYC=10, continuous=0, start pulse: address 0..7 each held 10 cycles, 7 step pulses, done once 80 cycles after RUN entry, busy falls with done.
REQ-031 continuous=1, DWELL_CYC=2: after address 7 the next value is 0 with step=1, no done; stop=1 -> next cycle IDLE, address 0, busy 0.
REQ-032 stop asserted in the same cycle as the 3->4 advance: address goes to 0 (not 4), no step, no done.
REQ-033 rst_n pulled low at address 5 mid-dwell: outputs 0 asynchronously; after release, start rescans from 0 with full 8*DWELL_CYC timing.
REQ-034 SCAN_SEQ_CHECK_EN, decoder connected: err stays 0 over a full pass; forcing z=8'h00 at address 3 sets err next cycle, err holds until next start.
